seq_run_ctl: RTL and testbench



---
 rtl/seq_run_ctl.sv | 118 +++++++++++
 tb/tb_seq_run_ctl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_run_ctl.sv
// Run sequencer for the serial sequence detector: clears the detector, shifts a
// programmed pattern into it MSB-first, and counts the detector's hit pulses.
module seq_run_ctl #(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic             det_dout,
  output logic             det_din,
  output logic             det_rst_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [2:0]       ctl_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    CLR   = 3'b001,
    SHIFT = 3'b010,
    DRAIN = 3'b011,
    DONE  = 3'b100
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  state_t           state;
  logic [PAT_W-1:0] sreg;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] len_eff;
  logic [PAT_W-1:0] pat_aligned;

  always_comb begin
    len_eff     = (len > LEN_MAX) ? LEN_MAX : len;
    pat_aligned = pat << (LEN_MAX - len_eff);
  end

  assign ctl_state = state;

  // Outputs are registered from the next-state decision, so det_din is stable
  // for the whole cycle and the detector's negedge samples it mid-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      det_din   <= 1'b0;
      det_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_cnt   <= '0;
    end else begin
      if ((state == SHIFT || state == DRAIN) && det_dout && hit_cnt != HIT_MAX)
        hit_cnt <= hit_cnt + 1'b1;

      case (state)
        IDLE: begin
          det_rst_n <= 1'b1;
          det_din   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            hit_cnt <= '0;
            if (len_eff != '0) begin
              state     <= CLR;
              sreg      <= pat_aligned;
              bit_cnt   <= len_eff;
              busy      <= 1'b1;
              det_rst_n <= 1'b0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        CLR: begin
          state     <= SHIFT;
          det_rst_n <= 1'b1;
          det_din   <= sreg[PAT_W-1];
          sreg      <= sreg << 1;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == LEN_W'(1)) begin
            state   <= DRAIN;
            det_din <= 1'b0;
          end else begin
            det_din <= sreg[PAT_W-1];
            sreg    <= sreg << 1;
          end
        end
        DRAIN: begin
          state   <= DONE;
          det_din <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          det_din <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_run_ctl.sv
// Bench for seq_run_ctl: a behavioural 101011 overlapping detector closes the loop,
// and each run is scored against values derived directly from the pattern.
module tb_seq_run_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pat;
  logic [4:0]  len;
  logic        det_dout = 1'b0;
  logic        det_din;
  logic        det_rst_n;
  logic        busy;
  logic        done;
  logic [4:0]  hit_cnt;
  logic [2:0]  ctl_state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  seq_run_ctl #(.PAT_W(16), .LEN_W(5), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len),
    .det_dout(det_dout), .det_din(det_din), .det_rst_n(det_rst_n),
    .busy(busy), .done(done), .hit_cnt(hit_cnt), .ctl_state(ctl_state)
  );

  always #5 clk = ~clk;

  // Detector stand-in: remembers bits since its last reset, pulses on 101011.
  logic [5:0]  hist = '0;
  int unsigned nbits = 0;
  always @(negedge clk or negedge det_rst_n) begin
    if (!det_rst_n) begin
      hist     <= '0;
      nbits    <= 0;
      det_dout <= 1'b0;
    end else begin
      hist     <= {hist[4:0], det_din};
      nbits    <= (nbits < 6) ? nbits + 1 : 6;
      det_dout <= (nbits >= 5) && ({hist[4:0], det_din} == 6'b101011);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_hits(input logic [15:0] p, input int unsigned l);
    int unsigned h = 0;
    logic [5:0] w;
    for (int i = 5; i < int'(l); i++) begin
      for (int j = 0; j < 6; j++) w[5-j] = p[int'(l) - 1 - (i - 5 + j)];
      if (w == 6'b101011) h++;
    end
    return (h > 31) ? 31 : h;
  endfunction

  // {ctl_state, det_din, det_rst_n, busy, done}
  function automatic logic [6:0] obs_vec();
    return {ctl_state, det_din, det_rst_n, busy, done};
  endfunction

  task automatic run(input logic [15:0] p, input logic [4:0] l, input bit hold, input bit chg);
    int unsigned le;
    int unsigned eh;
    logic [6:0]  ev;
    le = (l > 5'd16) ? 16 : int'(l);
    eh = exp_hits(p, le);
    @(negedge clk);
    pat = p; len = l; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    if (le == 0) begin
      chk("len0_done", 32'(obs_vec()), 32'({3'd4, 1'b0, 1'b1, 1'b0, 1'b1}));
      chk("len0_hits", 32'(hit_cnt), 32'd0);
    end else begin
      for (int unsigned k = 0; k <= le + 2; k++) begin
        if (k > 0) begin
          @(posedge clk); #1;
        end
        if (chg && k == 2) pat = ~p;
        if (k == 0)           ev = {3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        else if (k <= le)     ev = {3'd2, p[le-k], 1'b1, 1'b1, 1'b0};
        else if (k == le + 1) ev = {3'd3, 1'b0, 1'b1, 1'b1, 1'b0};
        else                  ev = {3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
        chk($sformatf("run_%04h_l%0d_c%0d", p, le, k), 32'(obs_vec()), 32'(ev));
      end
      chk($sformatf("hits_%04h_l%0d", p, le), 32'(hit_cnt), 32'(eh));
    end
    @(posedge clk); #1;
    chk("idle_after", 32'(obs_vec()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    chk("hits_held", 32'(hit_cnt), 32'(eh));
  endtask

  initial begin
    bit         seen_done;
    logic [15:0] rp;
    rst = 1'b0; start = 1'b0; pat = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs_vec()), 32'd0);
    chk("reset_hits", 32'(hit_cnt), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_n_rises", 32'(obs_vec()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

    run(16'h002B, 5'd6, 1'b0, 1'b0);
    run(16'hAD6B, 5'd16, 1'b0, 1'b0);
    run(16'h0015, 5'd5, 1'b0, 1'b0);
    run(16'h0015, 5'd0, 1'b0, 1'b0);

    // start held through the run with pat disturbed, then re-accepted from IDLE
    run(16'h002B, 5'd6, 1'b1, 1'b1);
    run(16'hAD6B, 5'd16, 1'b0, 1'b0);

    repeat (3) run(16'h002B, 5'd6, 1'b0, 1'b0);

    // abort during SHIFT bit 3
    @(negedge clk); pat = 16'hAD6B; len = 5'd16; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("abort_outputs", 32'(obs_vec()), 32'd0);
    chk("abort_hits", 32'(hit_cnt), 32'd0);
    @(negedge clk); rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_idle", 32'(obs_vec()), 32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0}));
    run(16'h002B, 5'd6, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rp = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rp[$urandom_range(0, 10) +: 6] = 6'b101011;
      run(rp, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
